iq_entry_scheduler: RTL and testbench

Entry manager and select arbiter for the issue queue. Tracks occupancy of every issue-queue slot and hands out up to two free slot numbers per cycle to dispatch. Keeps a per-slot age matrix and, each cycle, grants the oldest ready slot on each of the two execution ports. Frees issued slots and flushes wrong-path slots on a branch misprediction.

---
 rtl/iq_entry_scheduler.sv | 210 +++++++++++++++++++++
 tb/tb_iq_entry_scheduler.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/iq_entry_scheduler.sv
// Issue-queue entry manager and two-port oldest-ready select arbiter.
// Tracks slot occupancy, offers the two lowest free slots to dispatch, keeps
// a per-slot age matrix for oldest-first select, and flushes wrong-path slots
// on a branch misprediction.
module iq_entry_scheduler #(
  parameter int unsigned ENT_NUM = 16,
  parameter int unsigned ENT_SEL = 4,
  parameter int unsigned ROB_SEL = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall_DP,
  input  logic               alloc_req_1,
  input  logic               alloc_req_2,
  input  logic               alloc_port_1,
  input  logic               alloc_port_2,
  input  logic [ROB_SEL-1:0] alloc_rob_1,
  input  logic [ROB_SEL-1:0] alloc_rob_2,
  input  logic               alloc_sb_1,
  input  logic               alloc_sb_2,
  output logic [ENT_SEL-1:0] alloc_ent_1,
  output logic [ENT_SEL-1:0] alloc_ent_2,
  output logic               allocatable,
  output logic [ENT_SEL:0]   free_cnt,
  input  logic [ENT_NUM-1:0] ready_vec,
  input  logic               fu_busy_0,
  input  logic               fu_busy_1,
  output logic               issue_valid_0,
  output logic               issue_valid_1,
  output logic [ENT_SEL-1:0] issue_ent_0,
  output logic [ENT_SEL-1:0] issue_ent_1,
  output logic [ENT_NUM-1:0] valid_vec,
  input  logic               prmiss,
  input  logic [ROB_SEL-1:0] prmiss_rob_num,
  input  logic               prmiss_sorting_bit
);

  localparam int unsigned CW = ENT_SEL + 1;

  // Slot state
  logic [ENT_NUM-1:0] valid_q, valid_d;
  logic [ENT_NUM-1:0] port_q, port_d;
  logic [ENT_NUM-1:0] sb_q, sb_d;
  logic [ROB_SEL-1:0] rob_q [ENT_NUM];
  logic [ROB_SEL-1:0] rob_d [ENT_NUM];
  // older_q[i][j] = 1 means slot i is older than slot j
  logic [ENT_NUM-1:0] older_q [ENT_NUM];
  logic [ENT_NUM-1:0] older_d [ENT_NUM];
  logic [CW-1:0]      free_cnt_q, free_cnt_d;

  // Allocation
  logic               first_found, second_found;
  logic               alloc_ok, we_1, we_2;
  logic               wr1_port, wr1_sb;
  logic [ROB_SEL-1:0] wr1_rob;

  // Select
  logic [ENT_NUM-1:0] cand_0, cand_1;
  logic [ENT_NUM-1:0] blocked_0, blocked_1;
  logic [ENT_NUM-1:0] oldest_0, oldest_1;
  logic               found_0, found_1;
  logic [ENT_NUM-1:0] iss_oh_0, iss_oh_1;

  // Flush
  logic [ENT_NUM-1:0] kill;
  logic [CW-1:0]      kill_cnt, alloc_cnt, issue_cnt;

  assign valid_vec   = valid_q;
  assign free_cnt    = free_cnt_q;
  assign allocatable = (free_cnt_q >= CW'(2));

  // Offer the lowest and second-lowest free slots
  always_comb begin
    first_found  = 1'b0;
    second_found = 1'b0;
    alloc_ent_1  = '0;
    alloc_ent_2  = '0;
    for (int i = 0; i < ENT_NUM; i++) begin
      if (!valid_q[i]) begin
        if (!first_found) begin
          alloc_ent_1 = ENT_SEL'(i);
          first_found = 1'b1;
        end else if (!second_found) begin
          alloc_ent_2  = ENT_SEL'(i);
          second_found = 1'b1;
        end
      end
    end
  end

  // A lone request on dispatch slot 2 takes the first offered slot
  assign alloc_ok = ~reset & allocatable & ~stall_DP & ~prmiss;
  assign we_1     = alloc_ok & (alloc_req_1 | alloc_req_2);
  assign we_2     = alloc_ok & alloc_req_1 & alloc_req_2;
  assign wr1_port = alloc_req_1 ? alloc_port_1 : alloc_port_2;
  assign wr1_sb   = alloc_req_1 ? alloc_sb_1 : alloc_sb_2;
  assign wr1_rob  = alloc_req_1 ? alloc_rob_1 : alloc_rob_2;

  // Oldest-ready select per port: a candidate wins if no other candidate is older
  always_comb begin
    cand_0    = valid_q & ready_vec & ~port_q;
    cand_1    = valid_q & ready_vec & port_q;
    blocked_0 = '0;
    blocked_1 = '0;
    for (int c = 0; c < ENT_NUM; c++) begin
      for (int j = 0; j < ENT_NUM; j++) begin
        if (cand_0[j] && older_q[j][c]) blocked_0[c] = 1'b1;
        if (cand_1[j] && older_q[j][c]) blocked_1[c] = 1'b1;
      end
    end
    oldest_0    = cand_0 & ~blocked_0;
    oldest_1    = cand_1 & ~blocked_1;
    found_0     = 1'b0;
    found_1     = 1'b0;
    issue_ent_0 = '0;
    issue_ent_1 = '0;
    for (int i = 0; i < ENT_NUM; i++) begin
      if (oldest_0[i] && !found_0) begin
        issue_ent_0 = ENT_SEL'(i);
        found_0     = 1'b1;
      end
      if (oldest_1[i] && !found_1) begin
        issue_ent_1 = ENT_SEL'(i);
        found_1     = 1'b1;
      end
    end
  end

  assign issue_valid_0 = (|cand_0) & ~fu_busy_0 & ~prmiss & ~reset;
  assign issue_valid_1 = (|cand_1) & ~fu_busy_1 & ~prmiss & ~reset;
  assign iss_oh_0      = issue_valid_0 ? (ENT_NUM'(1) << issue_ent_0) : '0;
  assign iss_oh_1      = issue_valid_1 ? (ENT_NUM'(1) << issue_ent_1) : '0;

  // Kill valid slots strictly younger than the mispredicted branch
  always_comb begin
    kill     = '0;
    kill_cnt = '0;
    for (int s = 0; s < ENT_NUM; s++) begin
      if (prmiss && valid_q[s]) begin
        if (sb_q[s] == prmiss_sorting_bit) kill[s] = (rob_q[s] > prmiss_rob_num);
        else                               kill[s] = (rob_q[s] < prmiss_rob_num);
      end
      kill_cnt = kill_cnt + CW'(kill[s]);
    end
  end

  // Free-slot counter next state
  always_comb begin
    alloc_cnt  = CW'(we_1) + CW'(we_2);
    issue_cnt  = CW'(issue_valid_0) + CW'(issue_valid_1);
    free_cnt_d = free_cnt_q + issue_cnt + kill_cnt - alloc_cnt;
  end

  // Occupancy, payload and age-matrix next state
  always_comb begin
    valid_d = valid_q & ~iss_oh_0 & ~iss_oh_1 & ~kill;
    port_d  = port_q;
    sb_d    = sb_q;
    for (int i = 0; i < ENT_NUM; i++) begin
      rob_d[i]   = rob_q[i];
      older_d[i] = older_q[i];
    end
    if (we_1) begin
      valid_d[alloc_ent_1] = 1'b1;
      port_d[alloc_ent_1]  = wr1_port;
      sb_d[alloc_ent_1]    = wr1_sb;
      rob_d[alloc_ent_1]   = wr1_rob;
      older_d[alloc_ent_1] = '0;
      for (int j = 0; j < ENT_NUM; j++) begin
        if (valid_q[j]) older_d[j][alloc_ent_1] = 1'b1;
      end
    end
    if (we_2) begin
      valid_d[alloc_ent_2] = 1'b1;
      port_d[alloc_ent_2]  = alloc_port_2;
      sb_d[alloc_ent_2]    = alloc_sb_2;
      rob_d[alloc_ent_2]   = alloc_rob_2;
      older_d[alloc_ent_2] = '0;
      for (int j = 0; j < ENT_NUM; j++) begin
        if (valid_q[j]) older_d[j][alloc_ent_2] = 1'b1;
      end
      // Program-order older dispatch slot 1 ranks ahead of slot 2
      older_d[alloc_ent_1][alloc_ent_2] = 1'b1;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q    <= '0;
      port_q     <= '0;
      sb_q       <= '0;
      free_cnt_q <= CW'(ENT_NUM);
      for (int i = 0; i < ENT_NUM; i++) begin
        rob_q[i]   <= '0;
        older_q[i] <= '0;
      end
    end else begin
      valid_q    <= valid_d;
      port_q     <= port_d;
      sb_q       <= sb_d;
      free_cnt_q <= free_cnt_d;
      for (int i = 0; i < ENT_NUM; i++) begin
        rob_q[i]   <= rob_d[i];
        older_q[i] <= older_d[i];
      end
    end
  end

endmodule

// File: tb/tb_iq_entry_scheduler.sv
// Table-driven bench for iq_entry_scheduler: one row per clock cycle holding
// the inputs for that cycle and the outputs expected before its closing edge.
module tb_iq_entry_scheduler;

  localparam int unsigned EN = 16;
  localparam int unsigned ES = 4;
  localparam int unsigned RS = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          stall_DP;
  logic          alloc_req_1, alloc_req_2;
  logic          alloc_port_1, alloc_port_2;
  logic [RS-1:0] alloc_rob_1, alloc_rob_2;
  logic          alloc_sb_1, alloc_sb_2;
  logic [ES-1:0] alloc_ent_1, alloc_ent_2;
  logic          allocatable;
  logic [ES:0]   free_cnt;
  logic [EN-1:0] ready_vec;
  logic          fu_busy_0, fu_busy_1;
  logic          issue_valid_0, issue_valid_1;
  logic [ES-1:0] issue_ent_0, issue_ent_1;
  logic [EN-1:0] valid_vec;
  logic          prmiss;
  logic [RS-1:0] prmiss_rob_num;
  logic          prmiss_sorting_bit;

  always #5 clk = ~clk;

  iq_entry_scheduler #(
    .ENT_NUM(EN),
    .ENT_SEL(ES),
    .ROB_SEL(RS)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .stall_DP           (stall_DP),
    .alloc_req_1        (alloc_req_1),
    .alloc_req_2        (alloc_req_2),
    .alloc_port_1       (alloc_port_1),
    .alloc_port_2       (alloc_port_2),
    .alloc_rob_1        (alloc_rob_1),
    .alloc_rob_2        (alloc_rob_2),
    .alloc_sb_1         (alloc_sb_1),
    .alloc_sb_2         (alloc_sb_2),
    .alloc_ent_1        (alloc_ent_1),
    .alloc_ent_2        (alloc_ent_2),
    .allocatable        (allocatable),
    .free_cnt           (free_cnt),
    .ready_vec          (ready_vec),
    .fu_busy_0          (fu_busy_0),
    .fu_busy_1          (fu_busy_1),
    .issue_valid_0      (issue_valid_0),
    .issue_valid_1      (issue_valid_1),
    .issue_ent_0        (issue_ent_0),
    .issue_ent_1        (issue_ent_1),
    .valid_vec          (valid_vec),
    .prmiss             (prmiss),
    .prmiss_rob_num     (prmiss_rob_num),
    .prmiss_sorting_bit (prmiss_sorting_bit)
  );

  // req/port/sb: bit0 = dispatch slot 1, bit1 = slot 2; busy/iv: bit0 = port 0
  typedef struct {
    int unsigned rst, stall, req, port, rob1, rob2, sb, ready, busy, pm, prob, psb;
    int unsigned e1, e2, alc, fc, iv, ie0, ie1, vv;
  } vec_t;

  vec_t tbl[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input int unsigned rst, stall, req, port, rob1, rob2, sb, ready, busy,
                     input int unsigned pm, prob, psb, e1, e2, alc, fc, iv, ie0, ie1, vv);
    vec_t v;
    v.rst = rst; v.stall = stall; v.req = req; v.port = port; v.rob1 = rob1; v.rob2 = rob2;
    v.sb = sb; v.ready = ready; v.busy = busy; v.pm = pm; v.prob = prob; v.psb = psb;
    v.e1 = e1; v.e2 = e2; v.alc = alc; v.fc = fc; v.iv = iv; v.ie0 = ie0; v.ie1 = ie1;
    v.vv = vv;
    tbl.push_back(v);
  endtask

  task automatic idle();
    reset = 1'b0; stall_DP = 1'b0;
    alloc_req_1 = 1'b0; alloc_req_2 = 1'b0; alloc_port_1 = 1'b0; alloc_port_2 = 1'b0;
    alloc_rob_1 = '0; alloc_rob_2 = '0; alloc_sb_1 = 1'b0; alloc_sb_2 = 1'b0;
    ready_vec = '0; fu_busy_0 = 1'b0; fu_busy_1 = 1'b0;
    prmiss = 1'b0; prmiss_rob_num = '0; prmiss_sorting_bit = 1'b0;
  endtask

  task automatic check_inv(input string tag);
    check({tag, " free_cnt==popcount(~valid_vec)"}, 32'(free_cnt), 32'($countones(~valid_vec)));
  endtask

  task automatic apply(input vec_t v, input int idx);
    string t;
    t = $sformatf("row%0d", idx);
    @(negedge clk);
    reset = v.rst[0]; stall_DP = v.stall[0];
    alloc_req_1 = v.req[0]; alloc_req_2 = v.req[1];
    alloc_port_1 = v.port[0]; alloc_port_2 = v.port[1];
    alloc_rob_1 = RS'(v.rob1); alloc_rob_2 = RS'(v.rob2);
    alloc_sb_1 = v.sb[0]; alloc_sb_2 = v.sb[1];
    ready_vec = EN'(v.ready); fu_busy_0 = v.busy[0]; fu_busy_1 = v.busy[1];
    prmiss = v.pm[0]; prmiss_rob_num = RS'(v.prob); prmiss_sorting_bit = v.psb[0];
    #4;
    if (v.alc[0]) begin
      check({t, " alloc_ent_1"}, 32'(alloc_ent_1), v.e1);
      check({t, " alloc_ent_2"}, 32'(alloc_ent_2), v.e2);
    end
    check({t, " allocatable"}, 32'(allocatable), v.alc);
    check({t, " free_cnt"}, 32'(free_cnt), v.fc);
    check({t, " valid_vec"}, 32'(valid_vec), v.vv);
    check({t, " issue_valid_0"}, 32'(issue_valid_0), 32'(v.iv[0]));
    check({t, " issue_valid_1"}, 32'(issue_valid_1), 32'(v.iv[1]));
    if (v.iv[0]) check({t, " issue_ent_0"}, 32'(issue_ent_0), v.ie0);
    if (v.iv[1]) check({t, " issue_ent_1"}, 32'(issue_ent_1), v.ie1);
    check_inv(t);
  endtask

  task automatic build();
    // rst,stl,req,port,rob1,rob2,sb,ready,busy,pm,prob,psb | e1,e2,alc,fc,iv,ie0,ie1,vv
    // Fill all 16 slots two per cycle, then overflow request, then reset with grant pending
    add(0,0,3,0,0,0,0,'h0,0,0,0,0,   0, 1,1,16,0,0,0,'h0000);
    add(0,0,3,0,0,0,0,'h0,0,0,0,0,   2, 3,1,14,0,0,0,'h0003);
    add(0,0,3,0,0,0,0,'h0,0,0,0,0,   4, 5,1,12,0,0,0,'h000F);
    add(0,0,3,0,0,0,0,'h0,0,0,0,0,   6, 7,1,10,0,0,0,'h003F);
    add(0,0,3,0,0,0,0,'h0,0,0,0,0,   8, 9,1, 8,0,0,0,'h00FF);
    add(0,0,3,0,0,0,0,'h0,0,0,0,0,  10,11,1, 6,0,0,0,'h03FF);
    add(0,0,3,0,0,0,0,'h0,0,0,0,0,  12,13,1, 4,0,0,0,'h0FFF);
    add(0,0,3,0,0,0,0,'h0,0,0,0,0,  14,15,1, 2,0,0,0,'h3FFF);
    add(0,0,3,0,0,0,0,'h0,0,0,0,0,   0, 0,0, 0,0,0,0,'hFFFF);
    add(0,0,0,0,0,0,0,'h0,0,0,0,0,   0, 0,0, 0,0,0,0,'hFFFF);
    add(1,0,0,0,0,0,0,'hFFFF,0,0,0,0,0,0,0, 0,0,0,0,'hFFFF);
    // Port-0 slots 0,1,2 issue in age order
    add(0,0,3,0,0,0,0,'h0,0,0,0,0,   0, 1,1,16,0,0,0,'h0000);
    add(0,0,1,0,0,0,0,'h0,0,0,0,0,   2, 3,1,14,0,0,0,'h0003);
    add(0,0,0,0,0,0,0,'h7,0,0,0,0,   3, 4,1,13,1,0,0,'h0007);
    add(0,0,0,0,0,0,0,'h7,0,0,0,0,   0, 3,1,14,1,1,0,'h0006);
    add(0,0,0,0,0,0,0,'h7,0,0,0,0,   0, 1,1,15,1,2,0,'h0004);
    add(0,0,0,0,0,0,0,'h0,0,0,0,0,   0, 1,1,16,0,0,0,'h0000);
    // Age over slot reuse on port 1: order 1,2,3,0
    add(0,0,3,3,0,0,0,'h0,0,0,0,0,   0, 1,1,16,0,0,0,'h0000);
    add(0,0,3,3,0,0,0,'h0,0,0,0,0,   2, 3,1,14,0,0,0,'h0003);
    add(0,0,0,0,0,0,0,'h1,0,0,0,0,   4, 5,1,12,2,0,0,'h000F);
    add(0,0,1,1,0,0,0,'h0,0,0,0,0,   0, 4,1,13,0,0,0,'h000E);
    add(0,0,0,0,0,0,0,'hF,0,0,0,0,   4, 5,1,12,2,0,1,'h000F);
    add(0,0,0,0,0,0,0,'hF,0,0,0,0,   1, 4,1,13,2,0,2,'h000D);
    add(0,0,0,0,0,0,0,'hF,0,0,0,0,   1, 2,1,14,2,0,3,'h0009);
    add(0,0,0,0,0,0,0,'hF,0,0,0,0,   1, 2,1,15,2,0,0,'h0001);
    add(0,0,0,0,0,0,0,'h0,0,0,0,0,   0, 1,1,16,0,0,0,'h0000);
    // fu_busy_0 holds port 0, port 1 still issues; lone req_2; stalled request
    add(0,0,3,2,0,0,0,'h0,0,0,0,0,   0, 1,1,16,0,0,0,'h0000);
    add(0,0,1,1,0,0,0,'h0,0,0,0,0,   2, 3,1,14,0,0,0,'h0003);
    add(0,0,2,0,0,0,0,'h7,1,0,0,0,   3, 4,1,13,2,0,1,'h0007);
    add(0,0,0,0,0,0,0,'hF,0,0,0,0,   1, 4,1,13,3,0,2,'h000D);
    add(0,1,1,0,0,0,0,'hF,0,0,0,0,   0, 1,1,15,1,3,0,'h0008);
    add(0,0,0,0,0,0,0,'h0,0,0,0,0,   0, 1,1,16,0,0,0,'h0000);
    // Flush: rob 5,6,7 sb0 and rob 1 sb1; branch rob 6 sb0 kills rob 7 and rob 1
    add(0,0,3,0,5,6,0,'h0,0,0,0,0,   0, 1,1,16,0,0,0,'h0000);
    add(0,0,3,0,7,1,2,'h0,0,0,0,0,   2, 3,1,14,0,0,0,'h0003);
    add(0,0,1,0,9,0,0,'hF,0,1,6,0,   4, 5,1,12,0,0,0,'h000F);
    add(0,0,0,0,0,0,0,'hF,0,0,0,0,   2, 3,1,14,1,0,0,'h0003);
    add(0,0,0,0,0,0,0,'hF,0,0,0,0,   0, 2,1,15,1,1,0,'h0002);
    add(0,0,0,0,0,0,0,'h0,0,0,0,0,   0, 1,1,16,0,0,0,'h0000);
    // Reset mid-stream with 10 valid slots and a ready request
    add(0,0,3,0,0,0,0,'h0,0,0,0,0,   0, 1,1,16,0,0,0,'h0000);
    add(0,0,3,0,0,0,0,'h0,0,0,0,0,   2, 3,1,14,0,0,0,'h0003);
    add(0,0,3,0,0,0,0,'h0,0,0,0,0,   4, 5,1,12,0,0,0,'h000F);
    add(0,0,3,0,0,0,0,'h0,0,0,0,0,   6, 7,1,10,0,0,0,'h003F);
    add(0,0,3,0,0,0,0,'h0,0,0,0,0,   8, 9,1, 8,0,0,0,'h00FF);
    add(1,0,3,0,0,0,0,'h3FF,0,0,0,0, 10,11,1,6,0,0,0,'h03FF);
    add(0,0,0,0,0,0,0,'h3FF,0,0,0,0,  0, 1,1,16,0,0,0,'h0000);
  endtask

  initial begin
    idle();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    build();
    foreach (tbl[i]) apply(tbl[i], i);

    // Wrapped-phase flush: branch rob 2 sb1; rob 60 sb0 and the branch survive,
    // rob 3 sb1 and rob 1 sb0 are younger and die
    @(negedge clk);
    idle();
    alloc_req_1 = 1'b1; alloc_req_2 = 1'b1; alloc_port_1 = 1'b1; alloc_port_2 = 1'b1;
    alloc_rob_1 = 6'd60; alloc_sb_1 = 1'b0; alloc_rob_2 = 6'd2; alloc_sb_2 = 1'b1;
    @(negedge clk);
    alloc_rob_1 = 6'd3; alloc_sb_1 = 1'b1; alloc_rob_2 = 6'd1; alloc_sb_2 = 1'b0;
    @(negedge clk);
    idle();
    prmiss = 1'b1; prmiss_rob_num = 6'd2; prmiss_sorting_bit = 1'b1; ready_vec = 16'h000F;
    #4;
    check("wrap prmiss issue_valid_1", 32'(issue_valid_1), 32'd0);
    check("wrap prmiss valid_vec", 32'(valid_vec), 32'h000F);
    check("wrap prmiss free_cnt", 32'(free_cnt), 32'd12);
    @(negedge clk);
    idle();
    #4;
    check("wrap after valid_vec", 32'(valid_vec), 32'h0003);
    check("wrap after free_cnt", 32'(free_cnt), 32'd14);
    check_inv("wrap after");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
